adc_spi_sampler: RTL
====================

ADC_SPI_SAMPLER -- requirements
Module: adc_spi_sampler

Interface
REQ-001 SHALL have parameter ADC_BITWIDTH, default 4: width of the averaged sample delivered to the fan controller.
REQ-002 SHALL have parameter SPI_BITWIDTH, default 8: bits read per conversion from the serial ADC, MSB first; must be >= ADC_BITWIDTH.
REQ-003 SHALL have parameter CLK_DIV, default 4: enabled clk_i cycles per spi_sclk_o half-period; must be >= 1.
REQ-004 SHALL have parameter SAMPLE_INTERVAL, default 50000: enabled cycles between conversion starts (50 ms at 1 MHz).
REQ-005 SHALL have parameter AVG_LOG2, default 2: log2 of conversions averaged per output sample.
REQ-006 SHALL have port clk_i, input, 1 bit: the block's single clock.
REQ-007 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port clk_en_i, input, 1 bit: cycle enable; when low, all state holds.
REQ-009 SHALL have port spi_miso_i, input, 1 bit: serial data from the ADC.
REQ-010 SHALL have port spi_cs_n_o, output, 1 bit: active-low ADC chip select.
REQ-011 SHALL have port spi_sclk_o, output, 1 bit: SPI clock, idle low.
REQ-012 SHALL have port ADC_value_o, output, ADC_BITWIDTH bits: averaged sample, fed to the fan controller's ADC input.
REQ-013 SHALL have port ADC_valid_o, output, 1 bit: one-cycle pulse when ADC_value_o updates.
REQ-014 SHALL have port busy_o, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, CS_SETUP, SHIFT, CS_HOLD and ACCUM, with transitions IDLE->CS_SETUP->SHIFT->CS_HOLD->ACCUM->IDLE.
REQ-016 Interval counter SHALL count enabled cycles from 0 to SAMPLE_INTERVAL-1 and wrap to 0; on wrap it SHALL set a start request.
REQ-017 In IDLE with a start request set, the FSM SHALL clear the request and enter CS_SETUP on the next enabled cycle, driving spi_cs_n_o low.
REQ-018 A wrap that occurs while busy_o is high SHALL leave the request set, so the conversion starts on the next return to IDLE; multiple wraps SHALL coalesce into one request.
REQ-019 CS_SETUP SHALL last CLK_DIV enabled cycles with spi_sclk_o low.
REQ-020 In SHIFT, spi_sclk_o SHALL toggle every CLK_DIV enabled cycles, giving SPI_BITWIDTH full periods.
REQ-021 On each enabled cycle in which spi_sclk_o goes low->high, the block SHALL shift spi_miso_i into the shift register LSB (MSB-first data).
REQ-022 SHIFT SHALL end after the SPI_BITWIDTH-th falling edge; CS_HOLD SHALL then last CLK_DIV enabled cycles with spi_sclk_o low.
REQ-023 spi_cs_n_o SHALL return high on exit from CS_HOLD.
REQ-024 Total conversion time SHALL be CLK_DIV*(2*SPI_BITWIDTH+2) enabled cycles.
REQ-025 ACCUM SHALL take one enabled cycle and add the shift register to an accumulator of SPI_BITWIDTH+AVG_LOG2 bits; this addition cannot overflow.
REQ-026 On the 2^AVG_LOG2-th accumulation, the block SHALL load ADC_value_o with accumulator bits [SPI_BITWIDTH+AVG_LOG2-1 : SPI_BITWIDTH+AVG_LOG2-ADC_BITWIDTH] (truncation, no rounding), clear the accumulator and conversion count, and pulse ADC_valid_o for exactly one clk_i cycle.
REQ-027 ADC_value_o SHALL hold its value between updates.
REQ-028 When clk_en_i is low, the FSM, counters, spi_sclk_o and spi_cs_n_o SHALL hold their values, and ADC_valid_o SHALL be 0.

Reset
REQ-029 While rst_i is high on a clk_i edge, the block SHALL set FSM=IDLE, set all counters, the accumulator and the shift register to 0, clear the start request, and drive spi_cs_n_o=1, spi_sclk_o=0, ADC_value_o=0, ADC_valid_o=0 and busy_o=0.
REQ-030 Reset asserted mid-conversion SHALL abort the conversion and discard partial averages; the first conversion after reset SHALL start SAMPLE_INTERVAL enabled cycles after reset deassertion.

Structure
REQ-031 The FSM state encoding SHALL live in a shared package, fan_ctrl_pkg, as the type adc_state_t, together with the default ADC_BITWIDTH constant shared with the fan controller.
REQ-032 The SPI shift engine (covering CS_SETUP/SHIFT/CS_HOLD timing) SHALL be a single sub-module, spi_rx_shifter, with a start/done handshake.
REQ-033 Averaging and interval logic SHALL remain in adc_spi_sampler.

Verification (CLK_DIV=2, SAMPLE_INTERVAL=64, AVG_LOG2=2, SPI_BITWIDTH=8, ADC_BITWIDTH=4, clk_en_i=1 unless stated)
REQ-034 Constant MISO model 0xA7 -> after 4 conversions ADC_valid_o pulses once and ADC_value_o=0xA; spi_cs_n_o low for exactly 36 cycles per conversion.
REQ-035 Conversions returning 0x10, 0x20, 0x30, 0x40 -> sum 0xA0, ADC_value_o=0x2.
REQ-036 All conversions 0xFF -> ADC_value_o=0xF with no accumulator wrap; next 4 conversions of 0x00 -> ADC_value_o=0x0.
REQ-037 rst_i pulsed during the 5th SHIFT bit -> spi_cs_n_o=1 and spi_sclk_o=0 the next cycle; ADC_valid_o stays 0 until 4 new full conversions complete.
REQ-038 clk_en_i toggled 1/0 on alternate cycles -> identical SCLK edge count and ADC_value_o result, with conversion time doubled to 72 clk_i cycles.
REQ-039 SAMPLE_INTERVAL=20 (shorter than the 36-cycle conversion) -> conversions run back to back with exactly one IDLE cycle between them and no lost or duplicated conversion.

Source files
------------

// File: rtl/fan_ctrl_pkg.sv
// Types and constants shared between the ADC sampler and the fan controller.
// Holds the conversion FSM encoding and the default averaged-sample width.
package fan_ctrl_pkg;

  localparam int ADC_BITWIDTH_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_ACCUM    = 3'd4
  } adc_state_t;

endpackage

// File: rtl/adc_spi_sampler_if.sv
// Start/done handshake between the sampler's averaging logic and its SPI shift engine.
// The master starts conversions; the slave reports busy, done and the received word.
interface adc_spi_sampler_if #(
  parameter int SPI_BITWIDTH = 8
) ();

  logic                    start;
  logic                    busy;
  logic                    done;
  logic [SPI_BITWIDTH-1:0] data;

  modport master (output start, input busy, done, data);
  modport slave  (input start, output busy, done, data);

endinterface

// File: rtl/spi_rx_shifter.sv
// SPI read engine: chip-select setup, SPI_BITWIDTH SCLK periods sampling MISO MSB first,
// chip-select hold, then a one-cycle ACCUM state that presents the word as done.
module spi_rx_shifter
  import fan_ctrl_pkg::*;
#(
  parameter int SPI_BITWIDTH = 8,
  parameter int CLK_DIV      = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clk_en_i,
  input  logic                     spi_miso_i,
  output logic                     spi_cs_n_o,
  output logic                     spi_sclk_o,
  adc_spi_sampler_if.slave         rx
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int HW = $clog2(2 * SPI_BITWIDTH + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(2 * SPI_BITWIDTH - 1);

  adc_state_t              state_q, state_d;
  logic [DW-1:0]           div_q, div_d;
  logic [HW-1:0]           half_q, half_d;
  logic                    sclk_q, sclk_d;
  logic [SPI_BITWIDTH-1:0] shift_q, shift_d;
  logic                    div_last;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    half_d   = half_q;
    sclk_d   = sclk_q;
    shift_d  = shift_q;
    div_last = (div_q == DIV_LAST);
    if (clk_en_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx.start) begin
            state_d = ST_CS_SETUP;
            div_d   = '0;
          end
        end
        ST_CS_SETUP: begin
          div_d = div_last ? '0 : div_q + 1'b1;
          if (div_last) begin
            state_d = ST_SHIFT;
            half_d  = '0;
          end
        end
        ST_SHIFT: begin
          div_d = div_last ? '0 : div_q + 1'b1;
          if (div_last) begin
            sclk_d = ~sclk_q;
            // Sample on the rising SCLK edge; the ADC updates MISO on the falling edge.
            if (!sclk_q) shift_d = SPI_BITWIDTH'({shift_q, spi_miso_i});
            if (half_q == HALF_LAST) state_d = ST_CS_HOLD;
            else                     half_d  = half_q + 1'b1;
          end
        end
        ST_CS_HOLD: begin
          div_d = div_last ? '0 : div_q + 1'b1;
          if (div_last) state_d = ST_ACCUM;
        end
        ST_ACCUM: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      half_q  <= '0;
      sclk_q  <= 1'b0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      half_q  <= half_d;
      sclk_q  <= sclk_d;
      shift_q <= shift_d;
    end
  end

  assign spi_sclk_o = sclk_q;
  assign spi_cs_n_o = !(state_q inside {ST_CS_SETUP, ST_SHIFT, ST_CS_HOLD});
  assign rx.busy    = (state_q != ST_IDLE);
  assign rx.done    = (state_q == ST_ACCUM);
  assign rx.data    = shift_q;

endmodule

// File: rtl/adc_spi_sampler.sv
// Periodic serial-ADC sampler: an interval counter requests conversions, the SPI engine
// reads them, and 2^AVG_LOG2 results are summed and truncated into ADC_value_o.
module adc_spi_sampler
  import fan_ctrl_pkg::*;
#(
  parameter int ADC_BITWIDTH    = ADC_BITWIDTH_DEFAULT,
  parameter int SPI_BITWIDTH    = 8,
  parameter int CLK_DIV         = 4,
  parameter int SAMPLE_INTERVAL = 50000,
  parameter int AVG_LOG2        = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clk_en_i,
  input  logic                    spi_miso_i,
  output logic                    spi_cs_n_o,
  output logic                    spi_sclk_o,
  output logic [ADC_BITWIDTH-1:0] ADC_value_o,
  output logic                    ADC_valid_o,
  output logic                    busy_o
);

  localparam int AW = SPI_BITWIDTH + AVG_LOG2;
  localparam int IW = $clog2(SAMPLE_INTERVAL + 1);
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [IW-1:0] INT_LAST  = IW'(SAMPLE_INTERVAL - 1);
  localparam logic [CW-1:0] CONV_LAST = CW'((1 << AVG_LOG2) - 1);

  adc_spi_sampler_if #(.SPI_BITWIDTH(SPI_BITWIDTH)) rx_if ();

  spi_rx_shifter #(
    .SPI_BITWIDTH(SPI_BITWIDTH),
    .CLK_DIV     (CLK_DIV)
  ) u_shifter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clk_en_i   (clk_en_i),
    .spi_miso_i (spi_miso_i),
    .spi_cs_n_o (spi_cs_n_o),
    .spi_sclk_o (spi_sclk_o),
    .rx         (rx_if.slave)
  );

  logic [IW-1:0]           int_q, int_d;
  logic                    req_q, req_d;
  logic [AW-1:0]           acc_q, acc_d;
  logic [CW-1:0]           conv_q, conv_d;
  logic [ADC_BITWIDTH-1:0] value_q, value_d;
  logic                    valid_q, valid_d;
  logic                    wrap, accept, update;
  logic [AW-1:0]           acc_sum;

  always_comb begin
    int_d   = int_q;
    acc_d   = acc_q;
    conv_d  = conv_q;
    value_d = value_q;
    update  = 1'b0;
    wrap    = clk_en_i && (int_q == INT_LAST);
    accept  = clk_en_i && req_q && !rx_if.busy;
    acc_sum = acc_q + AW'(rx_if.data);
    if (clk_en_i) int_d = wrap ? '0 : int_q + 1'b1;
    // A wrap during a conversion keeps (or coalesces into) the pending request.
    req_d = wrap || (req_q && !accept);
    if (clk_en_i && rx_if.done) begin
      if (conv_q == CONV_LAST) begin
        value_d = acc_sum[AW-1 -: ADC_BITWIDTH];
        acc_d   = '0;
        conv_d  = '0;
        update  = 1'b1;
      end else begin
        acc_d  = acc_sum;
        conv_d = conv_q + 1'b1;
      end
    end
    // The pulse waits for the next enabled cycle so it is never masked by clk_en_i.
    valid_d = clk_en_i ? update : valid_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      int_q   <= '0;
      req_q   <= 1'b0;
      acc_q   <= '0;
      conv_q  <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
    end else begin
      int_q   <= int_d;
      req_q   <= req_d;
      acc_q   <= acc_d;
      conv_q  <= conv_d;
      value_q <= value_d;
      valid_q <= valid_d;
    end
  end

  assign rx_if.start = req_q;
  assign ADC_value_o = value_q;
  assign ADC_valid_o = valid_q && clk_en_i;
  assign busy_o      = rx_if.busy;

endmodule
